// File: rtl/mem_copy_dma_if.sv
// Purpose : control/status and data-segment port bundle for mem_copy_dma.
// Latency : n/a (wires only).
// Backpressure: none; start is a pulse honoured only while the engine is idle.
// Ports   : start/src/dst/len (request), busy/done/err (status),
//           mem_a/mem_we/mem_wd (memory drive), mem_rd (memory read data).
interface mem_copy_dma_if #(
  parameter int WIDTH    = 32,
  parameter int LENWIDTH = 16
);
  logic                start;
  logic [WIDTH-1:0]    src;
  logic [WIDTH-1:0]    dst;
  logic [LENWIDTH-1:0] len;
  logic                busy;
  logic                done;
  logic                err;
  logic [WIDTH-1:0]    mem_a;
  logic                mem_we;
  logic [WIDTH-1:0]    mem_wd;
  logic [WIDTH-1:0]    mem_rd;

  // Copy engine side
  modport slave (
    input  start, src, dst, len, mem_rd,
    output busy, done, err, mem_a, mem_we, mem_wd
  );

  // Requester / memory side
  modport master (
    output start, src, dst, len, mem_rd,
    input  busy, done, err, mem_a, mem_we, mem_wd
  );
endinterface

// File: rtl/mem_copy_dma.sv
// Purpose : block copy engine for the segmented data memory, one word per READ/CAPTURE/WRITE pass.
// Latency : 3 cycles per word; done 3N+1 cycles after accept, 1 cycle for len=0 or out-of-range.
// Backpressure: none; start is ignored unless idle (not queued), memory assumed always ready.
// Ports   : clk, reset (sync active-low), bus (mem_copy_dma_if.slave): request
//           start/src/dst/len, status busy/done/err, memory mem_a/mem_we/mem_wd/mem_rd.
module mem_copy_dma #(
  parameter int WIDTH    = 32,
  parameter int RAMSIZE  = 128,
  parameter int NSEG     = 6,
  parameter int LENWIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  mem_copy_dma_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(RAMSIZE * NSEG);

  state_t              r_state;
  logic [WIDTH-1:0]    r_src_ptr;
  logic [WIDTH-1:0]    r_dst_ptr;
  logic [LENWIDTH-1:0] r_remaining;
  logic [WIDTH-1:0]    r_buf;
  logic [WIDTH-1:0]    r_mem_a;
  logic                r_mem_we;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  // One extra bit on the end-address sums so a source/destination near the
  // top of the address space cannot wrap back into the legal range.
  logic [WIDTH:0] w_len_ext;
  logic [WIDTH:0] w_src_end;
  logic [WIDTH:0] w_dst_end;
  logic           w_range_bad;

  assign w_len_ext   = {{(WIDTH+1-LENWIDTH){1'b0}}, bus.len};
  assign w_src_end   = {1'b0, bus.src} + w_len_ext;
  assign w_dst_end   = {1'b0, bus.dst} + w_len_ext;
  assign w_range_bad = (w_src_end > LIMIT) || (w_dst_end > LIMIT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_src_ptr   <= '0;
      r_dst_ptr   <= '0;
      r_remaining <= '0;
      r_buf       <= '0;
      r_mem_a     <= '0;
      r_mem_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_src_ptr   <= bus.src;
            r_dst_ptr   <= bus.dst;
            r_remaining <= bus.len;
            r_busy      <= 1'b1;
            if (bus.len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (w_range_bad) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_READ;
              r_mem_a <= bus.src;
            end
          end
        end

        // Address already presented on entry; memory answers next cycle.
        S_READ: begin
          r_state <= S_CAPTURE;
        end

        // mem_rd now holds the source word; mem_a stays on the source until
        // this edge, then moves to the destination for the write cycle.
        S_CAPTURE: begin
          r_buf    <= bus.mem_rd;
          r_mem_a  <= r_dst_ptr;
          r_mem_we <= 1'b1;
          r_state  <= S_WRITE;
        end

        S_WRITE: begin
          r_mem_we    <= 1'b0;
          r_buf       <= '0;
          r_src_ptr   <= r_src_ptr + 1'b1;
          r_dst_ptr   <= r_dst_ptr + 1'b1;
          r_remaining <= r_remaining - 1'b1;
          if (r_remaining == LENWIDTH'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_mem_a <= '0;
          end else begin
            r_state <= S_READ;
            r_mem_a <= r_src_ptr + 1'b1;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state  <= S_IDLE;
          r_mem_we <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
          r_err    <= 1'b0;
          r_mem_a  <= '0;
          r_buf    <= '0;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.err    = r_err;
  assign bus.mem_a  = r_mem_a;
  assign bus.mem_we = r_mem_we;
  // buf is cleared outside WRITE, so write data reads as zero when idle.
  assign bus.mem_wd = r_buf;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Purpose : self-checking bench for mem_copy_dma against an array-level copy model.
// Latency : checks done timing of 3N+1 cycles (valid) and 1 cycle (len=0 / rejected).
// Backpressure: checks that start while busy or during done is dropped.
module tb_mem_copy_dma;

  localparam int WIDTH    = 32;
  localparam int LENWIDTH = 16;
  localparam int MEMW     = 768;

  logic clk;
  logic reset;

  mem_copy_dma_if #(.WIDTH(WIDTH), .LENWIDTH(LENWIDTH)) mif ();

  mem_copy_dma #(
    .WIDTH(WIDTH), .RAMSIZE(128), .NSEG(6), .LENWIDTH(LENWIDTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: synchronous read, write on mem_we; a backdoor port
  // lets the bench preload words. Writes are blocked while reset is asserted.
  logic [31:0] mem [0:MEMW-1];
  logic        bd_we;
  int          bd_a;
  logic [31:0] bd_d;
  int          we_cnt;

  initial we_cnt = 0;

  always @(posedge clk) begin
    if (int'(mif.mem_a) < MEMW) mif.mem_rd <= mem[int'(mif.mem_a)];
    else                        mif.mem_rd <= 32'h0;
    if (bd_we) begin
      mem[bd_a] <= bd_d;
    end else if (reset && mif.mem_we) begin
      we_cnt <= we_cnt + 1;
      if (int'(mif.mem_a) < MEMW) mem[int'(mif.mem_a)] <= mif.mem_wd;
    end
  end

  logic [31:0] ref_mem [0:MEMW-1];
  int checks;
  int failures;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    bd_a  = a;
    bd_d  = d;
    bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic check_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < MEMW; i++) if (mem[i] !== ref_mem[i]) bad++;
    check(tag, bad, 0);
  endtask

  // Issue one request and check timing, status, write count and memory.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] l, input bit perturb, input string tag);
    longint s_end, d_end;
    int exp_lat, exp_we, cyc, bound, we_base;
    bit exp_err;
    s_end = longint'(s) + longint'(l);
    d_end = longint'(d) + longint'(l);
    if (l == 0) begin
      exp_lat = 1; exp_we = 0; exp_err = 0;
    end else if (s_end > MEMW || d_end > MEMW) begin
      exp_lat = 1; exp_we = 0; exp_err = 1;
    end else begin
      exp_lat = 3 * int'(l) + 1; exp_we = int'(l); exp_err = 0;
      for (int i = 0; i < int'(l); i++) ref_mem[int'(d) + i] = ref_mem[int'(s) + i];
    end
    bound = exp_lat + 10;

    @(negedge clk);
    we_base   = we_cnt;
    mif.start = 1'b1;
    mif.src   = s;
    mif.dst   = d;
    mif.len   = l;
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    check({tag, "_busy"}, mif.busy, 1);
    if (perturb) begin
      // Hold start high with unrelated values through the done cycle.
      mif.src = $urandom_range(0, 700);
      mif.dst = $urandom_range(0, 700);
      mif.len = 16'($urandom_range(1, 5));
    end else begin
      mif.start = 1'b0;
    end
    while (!mif.done && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, cyc, exp_lat);
    check({tag, "_err"}, mif.err, exp_err);
    check({tag, "_dbusy"}, mif.busy, 1);
    check({tag, "_dbus"}, {mif.mem_we, mif.mem_a}, 0);
    @(negedge clk);
    mif.start = 1'b0;
    check({tag, "_idle"}, {mif.busy, mif.done, mif.err}, 0);
    @(negedge clk);
    check({tag, "_noacc"}, mif.busy, 0);
    check({tag, "_wecnt"}, we_cnt - we_base, exp_we);
    check_mem({tag, "_mem"});
  endtask

  initial begin
    int cyc;
    int saw_done;
    checks    = 0;
    failures  = 0;
    bd_we     = 1'b0;
    bd_a      = 0;
    bd_d      = 0;
    reset     = 1'b0;
    mif.start = 1'b0;
    mif.src   = '0;
    mif.dst   = '0;
    mif.len   = '0;

    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < MEMW; i++) poke(i, $urandom);
    check("rst_status", {mif.busy, mif.done, mif.err, mif.mem_we}, 0);
    check("rst_a_wd", {mif.mem_a, mif.mem_wd}, 0);
    reset = 1'b1;
    @(negedge clk);

    // Reset during the second write: only the first word lands, no done.
    begin
      logic [31:0] w0;
      w0 = ref_mem[5];
      mif.start = 1'b1; mif.src = 5; mif.dst = 200; mif.len = 4;
      @(posedge clk);
      @(negedge clk);
      mif.start = 1'b0;
      cyc = 1;
      while (cyc < 6) begin
        @(negedge clk);
        cyc++;
      end
      check("rstmid_we2", {mif.mem_we, mif.mem_a}, {1'b1, 32'd201});
      reset = 1'b0;
      @(negedge clk);
      check("rstmid_after", {mif.mem_we, mif.busy}, 0);
      reset = 1'b1;
      saw_done = 0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (mif.done) saw_done++;
      end
      check("rstmid_nodone", saw_done, 0);
      ref_mem[200] = w0;
      check_mem("rstmid_mem");
    end

    // Basic copy
    poke(10, 32'hA); poke(11, 32'hB); poke(12, 32'hC); poke(13, 32'hD);
    run_copy(10, 300, 4, 0, "basic");
    check("basic_303", mem[303], 32'hD);

    // Segment crossing at 128 and 256
    poke(126, 1); poke(127, 2); poke(128, 3); poke(129, 4);
    run_copy(126, 254, 4, 0, "seg");
    check("seg_257", mem[257], 32'd4);

    // Range errors, zero length, ignored start
    run_copy(760, 0, 10, 0, "rng_src");
    run_copy(0, 767, 2, 0, "rng_dst");
    run_copy(32'hFFFF_FFFE, 0, 4, 0, "rng_wrap");
    run_copy(767, 767, 1, 0, "rng_edge");
    run_copy(50, 60, 0, 0, "zero");
    run_copy(40, 500, 3, 1, "ignore");

    // Overlap: forward propagation
    poke(20, 32'h1111); poke(21, 32'h2222); poke(22, 32'h3333);
    run_copy(20, 21, 3, 0, "ovl");
    check("ovl_23", mem[23], 32'h1111);

    // Randomised mix of valid, out-of-range and zero-length requests
    for (int n = 0; n < 40; n++) begin
      int kind;
      logic [15:0] l;
      logic [31:0] s, d;
      kind = $urandom_range(0, 9);
      l    = 16'($urandom_range(1, 8));
      s    = $urandom_range(0, MEMW - int'(l));
      d    = $urandom_range(0, MEMW - int'(l));
      if (kind == 7) s = MEMW - int'(l) + $urandom_range(1, 40);
      if (kind == 8) d = $urandom;
      if (kind == 9) l = 0;
      run_copy(s, d, l, $urandom_range(0, 3) == 0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
